// File: rtl/hexfmt_pkg.sv
// Shared types and ASCII constants for the hex LCD formatter.
// Leading-zero blanking is selected by HEXFMT_ZERO_BLANK_EN (see hex_lcd_formatter).
package hexfmt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    PULSE,
    WAIT
  } state_t;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_OFS = 8'd55;
  localparam logic [7:0] ASCII_SP    = 8'h20;

  localparam int LCD_CHARS = 32;

endpackage

// File: rtl/hexfmt_nib2ascii.sv
// Combinational nibble to ASCII hex digit, with a blank input that forces a space.
module hexfmt_nib2ascii
  import hexfmt_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_SP;
    if (!blank) begin
      if (nib < 4'd10) ascii = ASCII_0 + {4'h0, nib};
      else             ascii = ASCII_A_OFS + {4'h0, nib};
    end
  end

endmodule

// File: rtl/hex_lcd_formatter.sv
// Converts NCH channels of DW bits into a 32-char LCD string, one nibble per cycle,
// then pulses refresh_o and holds off. Define HEXFMT_ZERO_BLANK_EN to blank leading zeros.
module hex_lcd_formatter
  import hexfmt_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int DW   = 16,
  parameter int HOLD = 4
) (
  input  logic              CCLK,
  input  logic              RSTN,
  input  logic [NCH*DW-1:0] val_i,
  input  logic              force_i,
  output logic [255:0]      str_o,
  output logic              refresh_o,
  output logic              busy_o
);

  localparam int DIGITS = DW / 4;
  localparam int CHW    = $clog2(NCH + 1);
  localparam int DGW    = $clog2(DIGITS + 1);
  localparam int HW     = $clog2(HOLD + 1);

  state_t                         state, state_next;
  logic [NCH*DW-1:0]              snapshot;
  logic                           pending;
  logic [CHW-1:0]                 ch_cnt;
  logic [DGW-1:0]                 dig_cnt;
  logic [HW-1:0]                  hold_cnt;
  logic [LCD_CHARS-1:0][7:0]      str_q;
  logic                           refresh_q;
  logic                           busy_q;

  logic                           changed;
  logic                           start;
  logic                           last_nib;
  logic                           first_dig;
  logic                           last_dig;
  logic [3:0]                     nib;
  logic                           blank;
  logic [7:0]                     ascii;
  logic [4:0]                     char_idx;

  assign changed   = (val_i != snapshot);
  assign start     = (state == IDLE) && (pending || changed);
  assign first_dig = (dig_cnt == '0);
  assign last_dig  = (dig_cnt == DGW'(DIGITS - 1));
  assign last_nib  = last_dig && (ch_cnt == CHW'(NCH - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pending || changed) state_next = CONV;
      CONV:    if (last_nib) state_next = PULSE;
      PULSE:   state_next = WAIT;
      WAIT:    if (hold_cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // MS nibble of each channel comes first, so digit 0 sits at the top of the field.
  always_comb begin
    nib      = 4'(snapshot >> (int'(ch_cnt) * DW + (DIGITS - 1 - int'(dig_cnt)) * 4));
    char_idx = 5'(LCD_CHARS - 1 - (int'(ch_cnt) * (DIGITS + 1) + int'(dig_cnt)));
  end

`ifdef HEXFMT_ZERO_BLANK_EN
  logic seen_nz;
  logic seen_eff;

  assign seen_eff = !first_dig && seen_nz;
  assign blank    = (nib == 4'h0) && !seen_eff && !last_dig;

  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN)               seen_nz <= 1'b0;
    else if (state == CONV)  seen_nz <= seen_eff || (nib != 4'h0);
  end
`else
  assign blank = 1'b0;
`endif

  hexfmt_nib2ascii u_nib2ascii (
    .nib   (nib),
    .blank (blank),
    .ascii (ascii)
  );

  // Clearing pending on a start takes priority, so force_i alongside a change costs one pass.
  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      snapshot  <= '0;
      pending   <= 1'b1;
      ch_cnt    <= '0;
      dig_cnt   <= '0;
      hold_cnt  <= '0;
      str_q     <= {LCD_CHARS{ASCII_SP}};
      refresh_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_next;
      busy_q    <= (state_next != IDLE);
      refresh_q <= (state == PULSE);

      if (start) begin
        snapshot <= val_i;
        pending  <= 1'b0;
        ch_cnt   <= '0;
        dig_cnt  <= '0;
      end else if (force_i) begin
        pending  <= 1'b1;
      end

      if (state == CONV) begin
        str_q[char_idx] <= ascii;
        if (last_dig) begin
          dig_cnt <= '0;
          ch_cnt  <= ch_cnt + CHW'(1);
        end else begin
          dig_cnt <= dig_cnt + DGW'(1);
        end
      end

      if (state == PULSE)                         hold_cnt <= HW'(HOLD - 1);
      else if (state == WAIT && hold_cnt != '0)   hold_cnt <= hold_cnt - HW'(1);
    end
  end

  assign str_o     = str_q;
  assign refresh_o = refresh_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_hex_lcd_formatter.sv
// Directed bench: a 2x16-bit/HOLD=4 instance and a 4x8-bit/HOLD=1 instance.
module tb_hex_lcd_formatter;

  logic         CCLK;
  logic         RSTN;
  logic [31:0]  val_a;
  logic         force_a;
  logic [255:0] str_a;
  logic         refresh_a;
  logic         busy_a;
  logic [31:0]  val_b;
  logic         force_b;
  logic [255:0] str_b;
  logic         refresh_b;
  logic         busy_b;

  int errors = 0;
  int checks = 0;

  string s_reset, s_1a3f, s_ff, s_part, s_5555, s_b;

  hex_lcd_formatter #(.NCH(2), .DW(16), .HOLD(4)) dut_a (
    .CCLK(CCLK), .RSTN(RSTN), .val_i(val_a), .force_i(force_a),
    .str_o(str_a), .refresh_o(refresh_a), .busy_o(busy_a)
  );

  hex_lcd_formatter #(.NCH(4), .DW(8), .HOLD(1)) dut_b (
    .CCLK(CCLK), .RSTN(RSTN), .val_i(val_b), .force_i(force_b),
    .str_o(str_b), .refresh_o(refresh_b), .busy_o(busy_b)
  );

  initial CCLK = 1'b0;
  always #5 CCLK = ~CCLK;

  function automatic logic [255:0] mk(input string s);
    logic [255:0] r;
    r = {32{8'h20}};
    for (int k = 0; k < s.len() && k < 32; k++) r[255-8*k -: 8] = s[k];
    return r;
  endfunction

  task automatic step();
    @(posedge CCLK);
    @(negedge CCLK);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_str(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_idle_a();
    int i;
    for (i = 0; i < 40 && busy_a; i++) step();
    if (busy_a) begin
      checks++; errors++;
      $display("[TB] FAIL wait_idle_a: busy got 1 expected 0 within 40 cycles");
    end
  endtask

  task automatic wait_idle_b();
    int i;
    for (i = 0; i < 40 && busy_b; i++) step();
    if (busy_b) begin
      checks++; errors++;
      $display("[TB] FAIL wait_idle_b: busy got 1 expected 0 within 40 cycles");
    end
  endtask

  // Returns the number of steps until refresh_a is seen, 0 if never within max.
  task automatic find_refresh_a(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max && n == 0; i++) begin
      step();
      if (refresh_a) n = i;
    end
  endtask

  task automatic test_reset();
    int n;
    RSTN = 1'b0; val_a = '0; force_a = 1'b0; val_b = '0; force_b = 1'b0;
    step(); step();
    check_str("reset_str_a", str_a, mk(""));
    check_int("reset_refresh_a", int'(refresh_a), 0);
    check_int("reset_busy_a", int'(busy_a), 0);
    check_str("reset_str_b", str_b, mk(""));
    RSTN = 1'b1;
    find_refresh_a(30, n);
    check_int("first_refresh_latency", n, 10);
    check_str("first_str", str_a, mk(s_reset));
    check_int("busy_during_wait", int'(busy_a), 1);
    wait_idle_a();
  endtask

  task automatic test_change();
    int pulses = 0;
    int busy_cnt = 0;
    val_a[15:0] = 16'h1A3F;
    for (int i = 0; i < 30; i++) begin
      step();
      pulses += int'(refresh_a);
      busy_cnt += int'(busy_a);
    end
    check_int("change_pulses", pulses, 1);
    check_int("change_busy_cycles", busy_cnt, 13);
    check_str("change_str", str_a, mk(s_1a3f));
  endtask

  task automatic test_wait_toggle();
    int n;
    int extra = 0;
    int idle_busy = 1;
    val_a[31:16] = 16'h0001;
    find_refresh_a(20, n);
    check_int("toggle_first_latency", n, 10);
    val_a[31:16] = 16'h00FF;
    for (int i = 1; i <= 4; i++) begin
      step();
      extra += int'(refresh_a);
      if (i == 4) idle_busy = int'(busy_a);
    end
    check_int("toggle_no_pulse_in_wait", extra, 0);
    check_int("toggle_idle_busy", idle_busy, 0);
    step();
    check_int("toggle_restart_busy", int'(busy_a), 1);
    find_refresh_a(20, n);
    check_int("toggle_second_latency", n, 9);
    check_str("toggle_str", str_a, mk(s_ff));
  endtask

  task automatic test_force();
    int pulses = 0;
    wait_idle_a();
    force_a = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 0) force_a = 1'b0;
      pulses += int'(refresh_a);
    end
    check_int("force_single_pulses", pulses, 1);
    check_str("force_str", str_a, mk(s_ff));
    pulses = 0;
    force_a = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (i == 0) force_a = 1'b0;
      if (i == 3) force_a = 1'b1;
      if (i == 4) force_a = 1'b0;
      pulses += int'(refresh_a);
    end
    check_int("force_in_conv_pulses", pulses, 2);
    check_int("force_end_idle", int'(busy_a), 0);
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses = 0;
    wait_idle_a();
    val_a[15:0] = 16'h5555;
    for (int i = 0; i < 4; i++) step();
    check_str("mid_partial_str", str_a, mk(s_part));
    check_int("mid_busy_before", int'(busy_a), 1);
    RSTN = 1'b0;
    #1;
    check_str("mid_reset_str", str_a, mk(""));
    check_int("mid_reset_busy", int'(busy_a), 0);
    for (int i = 0; i < 2; i++) begin
      step();
      pulses += int'(refresh_a);
    end
    check_int("mid_reset_no_refresh", pulses, 0);
    RSTN = 1'b1;
    find_refresh_a(20, n);
    check_int("mid_forced_latency", n, 10);
    check_str("mid_forced_str", str_a, mk(s_5555));
  endtask

  task automatic test_small();
    int n = 0;
    wait_idle_b();
    val_b = 32'h09_F0_00_AB;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step();
      if (refresh_b) n = i;
    end
    check_int("small_latency", n, 10);
    check_str("small_str", str_b, mk(s_b));
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int min_gap = 1000;
    int max_gap = 0;
    int np = 0;
    wait_idle_b();
    for (int i = 0; i < 80; i++) begin
      val_b = val_b + 32'd1;
      step();
      if (refresh_b) begin
        if (last >= 0) begin
          if (i - last < min_gap) min_gap = i - last;
          if (i - last > max_gap) max_gap = i - last;
        end
        last = i;
        np++;
      end
    end
    check_int("b2b_pulse_count", np, 7);
    check_int("b2b_min_gap", min_gap, 11);
    check_int("b2b_max_gap", max_gap, 11);
  endtask

  initial begin
`ifdef HEXFMT_ZERO_BLANK_EN
    s_reset = "   0    0";
    s_1a3f  = "1A3F    0";
    s_ff    = "1A3F   FF";
    s_part  = "555F   FF";
    s_5555  = "5555   FF";
    s_b     = "AB  0 F0  9";
`else
    s_reset = "0000 0000";
    s_1a3f  = "1A3F 0000";
    s_ff    = "1A3F 00FF";
    s_part  = "555F 00FF";
    s_5555  = "5555 00FF";
    s_b     = "AB 00 F0 09";
`endif
    $display("[TB] starting hex_lcd_formatter bench");
    test_reset();
    test_change();
    test_wait_toggle();
    test_force();
    test_reset_mid();
    test_small();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
